// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants and types for the round-robin burst
// scheduler that drives a 1-to-4 demultiplexer select.
//   NCH     : number of output channels
//   CNT_W   : width of the per-burst beat counter (covers BURST up to 16)
//   state_t : scheduler FSM states
package demux_sched_pkg;

    localparam int NCH   = 4;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority finder.
// Searches req[] starting just after ptr (ptr+1, ptr+2, ptr+3, ptr, mod 4)
// and returns the first requesting index.
// Ports:
//   req[3:0]     in  : request vector
//   ptr[1:0]     in  : last granted index (lowest priority on this pick)
//   gnt_idx[1:0] out : chosen index (equals ptr when nothing requests)
//   gnt_any      out : at least one request present
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_any
);

    logic [1:0] idx;

    always_comb begin
        gnt_idx = ptr;
        gnt_any = 1'b0;
        idx     = ptr;
        // i == 4 wraps to ptr itself, so the last granted channel is
        // considered only after every other channel.
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!gnt_any && req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: round-robin burst scheduler driving a 1-to-4 demux.
// One valid/ready source stream is granted to one enabled channel at a time
// for BURST beats, then the grant rotates. Data is broadcast; only the
// valid strobes are demultiplexed.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   chan_en[3:0]   : per-channel enable, sampled every cycle
//   in_valid       : source has a beat
//   in_data[DW]    : source beat
//   in_ready       : source beat accepted when in_valid && in_ready
//   out_valid[3:0] : one-hot valid to channels 0..3
//   out_data[DW]   : broadcast copy of in_data
//   out_ready[3:0] : per-channel ready
//   select[1:0]    : granted channel (registered, stable through a burst)
//   busy           : high while in XFER (exposes the FSM state)
//
// Handshake: a beat moves on a rising edge where in_valid && in_ready.
// in_ready never depends on in_valid; in_valid, once raised, is expected to
// hold with stable data until the beat is taken.
module demux_rr_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] chan_en,
    input  logic           in_valid,
    input  logic [DW-1:0]  in_data,
    output logic           in_ready,
    output logic [NCH-1:0] out_valid,
    output logic [DW-1:0]  out_data,
    input  logic [NCH-1:0] out_ready,
    output logic [1:0]     select,
    output logic           busy
);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt, select_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       pick_idx;
    logic             pick_any;

    rr_pick u_pick (
        .req     (chan_en),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd3;    // first arbitration searches from channel 0
            select <= 2'd0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            select <= select_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        select_nxt = select;
        cnt_nxt    = cnt;
        out_valid  = '0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid && pick_any) begin
                    select_nxt = pick_idx;
                    cnt_nxt    = '0;
                    state_nxt  = XFER;
                end
            end
            XFER: begin
                if (!chan_en[select]) begin
                    // Granted channel disabled: abandon the burst with no
                    // beat this cycle, even if it would have been the last.
                    ptr_nxt   = select;
                    state_nxt = IDLE;
                end else begin
                    out_valid[select] = in_valid;
                    in_ready          = out_ready[select];
                    if (in_valid && out_ready[select]) begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == CNT_W'(BURST - 1)) begin
                            ptr_nxt   = select;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == XFER);
    assign out_data = in_data;

endmodule
